// File: rtl/fdct4_top.sv
// fdct4_top: streaming 4x4 forward integer DCT; row pass, ping-pong transpose bank, column pass.
module fdct4_top #(
  parameter int DW = 16,
  parameter int OUT_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  output logic signed [15:0]   dout,
  output logic                 dout_valid,
  output logic                 dout_last,
  output logic                 sat_flag
);
  localparam int WW = DW + 3;
  localparam int CW = DW + 6;
  localparam logic signed [CW:0] RND  = (CW+1)'((1 << OUT_SHIFT) >> 1);
  localparam logic signed [CW:0] MAXV = (CW+1)'(32767);
  localparam logic signed [CW:0] MINV = (CW+1)'(-32768);

  // Shared 4-point butterfly: returns sum_j C[k][j]*x[j]
  function automatic logic signed [CW-1:0] bfly(input logic signed [CW-1:0] a, b, c, d,
                                                input logic [1:0] k);
    logic signed [CW-1:0] s03, d03, s12, d12;
    s03 = a + d;
    d03 = a - d;
    s12 = b + c;
    d12 = b - c;
    return k == 2'd0 ? s03 + s12 :
           k == 2'd1 ? (d03 <<< 1) + d12 :
           k == 2'd2 ? s03 - s12 : d03 - (d12 <<< 1);
  endfunction

  logic [3:0]           r_cnt;
  logic signed [DW-1:0] r_xbuf [3];
  logic signed [WW-1:0] r_row [4];
  logic                 r_wact;
  logic [1:0]           r_wk, r_wrow;
  logic                 r_fbank, r_dbank, r_dact;
  logic [3:0]           r_dcnt;
  logic signed [WW-1:0] r_bank [2][16];
  logic signed [WW-1:0] w_w;
  logic signed [CW-1:0] w_col;
  logic signed [CW:0]   w_sh;
  logic                 w_hi, w_lo, w_start;
  logic signed [15:0]   w_sat;

  always_comb begin
    w_w = WW'(bfly(CW'(r_row[0]), CW'(r_row[1]), CW'(r_row[2]), CW'(r_row[3]), r_wk));
    w_col = bfly(CW'(r_bank[r_dbank][{2'd0, r_dcnt[3:2]}]), CW'(r_bank[r_dbank][{2'd1, r_dcnt[3:2]}]),
                 CW'(r_bank[r_dbank][{2'd2, r_dcnt[3:2]}]), CW'(r_bank[r_dbank][{2'd3, r_dcnt[3:2]}]),
                 r_dcnt[1:0]);
    w_sh = ((CW+1)'(w_col) + RND) >>> OUT_SHIFT;
    w_hi = w_sh > MAXV;
    w_lo = w_sh < MINV;
    w_sat = w_hi ? 16'sh7fff : w_lo ? 16'sh8000 : w_sh[15:0];
    w_start = r_wact && r_wk == 2'd3 && r_wrow == 2'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_wact <= 1'b0;
      r_wk <= '0;
      r_wrow <= '0;
      r_fbank <= 1'b0;
      r_dbank <= 1'b0;
      r_dact <= 1'b0;
      r_dcnt <= '0;
      dout <= '0;
      dout_valid <= 1'b0;
      dout_last <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (r_wact) begin
        r_bank[r_fbank][{r_wrow, r_wk}] <= w_w;
        r_wk <= r_wk + 2'd1;
        r_wact <= r_wk != 2'd3;
      end
      // A newly completed row overrides the tail of the previous row's writes
      if (din_valid) begin
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt[1:0] != 2'd3) r_xbuf[r_cnt[1:0]] <= din;
        else begin
          r_row[0] <= WW'(r_xbuf[0]);
          r_row[1] <= WW'(r_xbuf[1]);
          r_row[2] <= WW'(r_xbuf[2]);
          r_row[3] <= WW'(din);
          r_wact <= 1'b1;
          r_wk <= '0;
          r_wrow <= r_cnt[3:2];
        end
      end
      if (w_start) begin
        r_fbank <= ~r_fbank;
        r_dbank <= r_fbank;
        r_dact <= 1'b1;
        r_dcnt <= '0;
      end else if (r_dact) begin
        r_dcnt <= r_dcnt + 4'd1;
        r_dact <= r_dcnt != 4'd15;
      end
      dout_valid <= r_dact;
      dout_last <= r_dact && r_dcnt == 4'd15;
      sat_flag <= r_dact && (w_hi || w_lo);
      dout <= r_dact ? w_sat : 16'sd0;
    end
  end
endmodule

// File: tb/tb_fdct4_top.sv
// tb_fdct4_top: random and directed blocks checked against a matrix-product reference model.
module tb_fdct4_top;
  logic clk = 1'b0, rst = 1'b1, din_valid = 1'b0;
  logic signed [15:0] din = '0;
  logic signed [15:0] dout0, dout2;
  logic dv0, dv2, dl0, dl2, sf0, sf2;

  fdct4_top #(.DW(16), .OUT_SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dout(dout0), .dout_valid(dv0), .dout_last(dl0), .sat_flag(sf0));
  fdct4_top #(.DW(16), .OUT_SHIFT(2)) u_dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dout(dout2), .dout_valid(dv2), .dout_last(dl2), .sat_flag(sf2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0, bad = 0;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  localparam int C [4][4] = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};

  typedef struct {int y0; int s0; int y2; int s2; int cyc; int last;} exp_t;
  exp_t q[$];
  int xs[16];
  int xn = 0;

  function automatic int shft(input int y, input int s);
    return s > 0 ? (y + (1 << (s - 1))) >>> s : y;
  endfunction

  function automatic int clamp(input int y);
    return y > 32767 ? 32767 : y < -32768 ? -32768 : y;
  endfunction

  function automatic void model_block(input int t);
    exp_t e;
    int y;
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 4; k++) begin
        y = 0;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) y += C[k][i] * xs[i*4+j] * C[l][j];
        e.y0 = clamp(shft(y, 0));
        e.s0 = int'(e.y0 != shft(y, 0));
        e.y2 = clamp(shft(y, 2));
        e.s2 = int'(e.y2 != shft(y, 2));
        e.cyc = t + 6 + l*4 + k;
        e.last = int'(l == 3 && k == 3);
        q.push_back(e);
      end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      xn = 0;
      q.delete();
    end else begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        check("missed_output_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (dv0 || dv2) begin
        if (q.size() == 0 || q[0].cyc != cyc) check("valid_cycle", cyc, q.size() > 0 ? q[0].cyc : -1);
        else begin
          e = q.pop_front();
          check("dv0", int'(dv0), 1);
          check("dout0", int'(dout0), e.y0);
          check("sat0", int'(sf0), e.s0);
          check("last0", int'(dl0), e.last);
          check("dv2", int'(dv2), 1);
          check("dout_sh2", int'(dout2), e.y2);
          check("sat_sh2", int'(sf2), e.s2);
          check("last_sh2", int'(dl2), e.last);
        end
      end
      if (din_valid) begin
        xs[xn] = int'(din);
        xn++;
        if (xn == 16) begin
          model_block(cyc);
          xn = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic feed(input int v[16], input int gap);
    for (int n = 0; n < 16; n++) begin
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
        din_valid = 1'b0;
        din = 16'($urandom);
        tick();
      end
      din_valid = 1'b1;
      din = 16'(v[n]);
      tick();
    end
    din_valid = 1'b0;
  endtask

  int v[16];
  task automatic fill(input int a);
    foreach (v[i]) v[i] = a;
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    check("rst_dout_valid", int'(dv0 | dv2), 0);
    check("rst_dout", int'(dout0) | int'(dout2), 0);
    check("rst_last_sat", int'(dl0 | dl2 | sf0 | sf2), 0);
    tick();
    rst = 1'b0;
    idle(2);
    fill(1); feed(v, 0); idle(30);
    fill(0); v[0] = 1; feed(v, 0);
    fill(0); v[1] = 1; feed(v, 0); idle(30);
    fill(-32768); feed(v, 0); idle(30);
    fill(1); feed(v, 0);
    fill(2); feed(v, 0);
    fill(3); feed(v, 0); idle(30);
    foreach (v[i]) v[i] = int'($urandom_range(0, 65535)) - 32768;
    feed(v, 0); idle(30);
    feed(v, 40); idle(30);
    din_valid = 1'b1;
    for (int n = 0; n < 7; n++) begin
      din = 16'(n + 5);
      tick();
    end
    din_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fill(1); feed(v, 0); idle(30);
    fill(3); feed(v, 0); idle(30);
    for (int b = 0; b < 8; b++) begin
      foreach (v[i]) v[i] = b[0] ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 200)) - 100;
      feed(v, b[1] ? 30 : 0);
      if (b[2]) idle(int'($urandom_range(0, 20)));
    end
    idle(40);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
